cla_adder_pipe: RTL
===================

# cla_adder_pipe

Parametrised, pipelined carry-lookahead adder for the floating-point datapath. Operands of WIDTH bits are split into SLICE-bit slices. Each pipeline stage resolves one slice with full lookahead and registers its carry into the next stage. A valid/ready handshake with back-pressure lets the block sit between the mantissa aligner and the normaliser at one result per clock.

## Interface
- WIDTH, 32, operand/sum width; must be a multiple of SLICE
- SLICE, 16, bits resolved per pipeline stage; must be a multiple of 4
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts the beat this cycle
- in0  input  WIDTH  operand A
- in1  input  WIDTH  operand B
- carry_in  input  1  carry into bit 0
- sub  input  1  subtract mode; exists only with CLA_PIPE_SUB_EN
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result, registered
- carry_out  output  1  carry out of the MSB, registered
- overflow  output  1  signed (two's-complement) overflow, registered

## Operation
- NSTAGES = WIDTH/SLICE. Stage k adds slice k (bits k*SLICE +: SLICE) using the carry registered by stage k-1. Stage 0 uses carry_in.
- Operand upper slices travel skewed: slice k is delayed k cycles before its stage. Completed low slices travel deskewed, so `sum` presents all slices of one beat together.
- Each stage holds a valid bit. advance = !out_valid || out_ready. When advance = 1, every stage shifts one position; when advance = 0, all stages hold. Bubbles are not collapsed.
- in_ready = advance (combinational). A beat is accepted when in_valid && in_ready.
- carry_out is the carry out of bit WIDTH-1.
- overflow = carry into bit WIDTH-1 XOR carry_out.
- Arithmetic is modulo 2^WIDTH. No saturation.
- Reset, including mid-operation: all valid bits clear, in-flight beats are discarded, all data registers go to 0.

## Timing
- Reset values: out_valid 0, sum 0, carry_out 0, overflow 0. in_ready is 1 once rst deasserts, because out_valid = 0.
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t+NSTAGES-1. Example: 2 cycles for 32/16.
- Throughput: 1 beat/cycle while out_ready = 1.
- Back-pressure: with out_valid = 1 and out_ready = 0, sum/carry_out/overflow stay stable and in_ready = 0. There is no loss and no duplication, and order is preserved.
- If out_ready rises in the same cycle as a new in_valid, the output is consumed and the input is accepted on the same edge.
- Inputs are sampled only on acceptance. in0/in1 may change freely otherwise.

## Configuration
- CLA_PIPE_SUB_EN defined: the `sub` port exists. An accepted beat with sub = 1 computes in0 + ~in1 + 1, and carry_in is ignored. carry_out = 1 means no borrow. overflow uses the same rule applied to the inverted operand.
- CLA_PIPE_SUB_EN undefined: no `sub` port. The block is add-only and carry_in is honoured.

## Structure
- Shared package cla_pkg holds:
  - localparam CLA_GROUP = 4;
  - function cla_nstages(width, slice);
  - typedef of the per-stage pipeline record (valid, skewed operands, partial sum, carry).
- One sub-module: cla_slice. It is a combinational SLICE-bit lookahead built from 4-bit groups with group P/G, taking carry in and giving sum and carry out. cla_adder_pipe instantiates it NSTAGES times under generate.
- Elaboration check: WIDTH % SLICE == 0 and SLICE % 4 == 0. Any violation triggers $error.

## Test plan
- Carry chain across slice boundary (WIDTH=32, SLICE=16): in0=0xFFFFFFFF, in1=0x00000001, carry_in=0 -> after 2 cycles sum=0x00000000, carry_out=1, overflow=0.
- Signed overflow: 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, carry_out=0, overflow=1. Also 0x80000000 + 0x80000000 -> sum=0, carry_out=1, overflow=1.
- Back-pressure: 3 back-to-back beats (1+2, 3+4, 5+6) with out_ready held 0 for 4 cycles -> in_ready=0 once out_valid=1, sum stays 3. After release, sums 3, 7, 11 arrive in order, one per cycle, with no duplicates.
- Reset mid-stream: assert rst while 2 beats are in flight -> out_valid=0 and sum=0 immediately (asynchronous). After deassertion, no stale beat ever appears.
- Subtract (CLA_PIPE_SUB_EN): in0=5, in1=7, sub=1 -> sum=0xFFFFFFFE, carry_out=0, overflow=0. in0=7, in1=5 -> sum=2, carry_out=1.
- Random: 100k random beats with random in_valid/out_ready, checked against a behavioural {carry_out,sum} = in0+in1+carry_in scoreboard, at WIDTH/SLICE of 32/16, 64/16 and 16/4.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   CLA_GROUP          : bits per lookahead group
//   CLA_MAX_WIDTH      : widest operand a pipeline record can carry
//   cla_stage_t        : per-stage pipeline record
//   cla_nstages()      : number of pipeline stages for a WIDTH/SLICE pair
//   cla_group()        : 4-bit group lookahead, returns {G, P, carries}
package cla_pkg;

    localparam int unsigned CLA_GROUP     = 4;
    localparam int unsigned CLA_MAX_WIDTH = 128;

    // One beat as it sits in a pipeline stage. opa/opb keep the operand
    // slices not yet resolved; psum collects the slices already resolved.
    typedef struct packed {
        logic                     valid;
        logic                     carry;
        logic                     ovf;
        logic [CLA_MAX_WIDTH-1:0] opa;
        logic [CLA_MAX_WIDTH-1:0] opb;
        logic [CLA_MAX_WIDTH-1:0] psum;
    } cla_stage_t;

    function automatic int unsigned cla_nstages(input int unsigned width,
                                                input int unsigned slice);
        return width / slice;
    endfunction

    // Group generate/propagate plus the carry into each bit of the group.
    function automatic logic [CLA_GROUP+1:0] cla_group(input logic [CLA_GROUP-1:0] g,
                                                       input logic [CLA_GROUP-1:0] p,
                                                       input logic             c0);
        logic [CLA_GROUP-1:0] c;
        logic                 gg;
        logic                 pg;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pg   = &p;
        return {gg, pg, c};
    endfunction

endpackage

// File: rtl/cla_adder_pipe_if.sv
// Handshake and data bundle of the pipelined carry-lookahead adder.
//   in_valid/in_ready/in0/in1/carry_in : operand beat
//   sub                                : subtract mode, only with CLA_PIPE_SUB_EN
//   out_valid/out_ready/sum/carry_out/overflow : result beat
// Modports: master drives operands and out_ready, slave is the adder.
interface cla_adder_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             carry_in;
`ifdef CLA_PIPE_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid, in0, in1, carry_in,
`ifdef CLA_PIPE_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, in0, in1, carry_in,
`ifdef CLA_PIPE_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );

endinterface

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-lookahead adder built from 4-bit groups.
//   a_i, b_i : operand slices
//   cin_i    : carry into bit 0
//   sum_o    : slice sum
//   cout_o   : carry out of the top bit
//   cmsb_o   : carry into the top bit (for signed overflow)
module cla_slice
    import cla_pkg::*;
#(
    parameter int unsigned SLICE = 16
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             cin_i,
    output logic [SLICE-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);
    localparam int unsigned NGROUPS = SLICE / CLA_GROUP;

    logic [SLICE-1:0]     gen_c;
    logic [SLICE-1:0]     prop_c;
    logic [SLICE-1:0]     carry_c;
    logic [NGROUPS:0]     gcarry_c;
    logic [CLA_GROUP+1:0] grp_c;

    assign gen_c  = a_i & b_i;
    assign prop_c = a_i ^ b_i;

    // Group carries chain through group G/P; bit carries come from lookahead.
    always_comb begin
        gcarry_c    = '0;
        carry_c     = '0;
        grp_c       = '0;
        gcarry_c[0] = cin_i;
        for (int j = 0; j < int'(NGROUPS); j++) begin
            grp_c = cla_group(gen_c[j*CLA_GROUP +: CLA_GROUP],
                              prop_c[j*CLA_GROUP +: CLA_GROUP],
                              gcarry_c[j]);
            carry_c[j*CLA_GROUP +: CLA_GROUP] = grp_c[CLA_GROUP-1:0];
            gcarry_c[j+1] = grp_c[CLA_GROUP+1] | (grp_c[CLA_GROUP] & gcarry_c[j]);
        end
    end

    assign sum_o  = prop_c ^ carry_c;
    assign cout_o = gcarry_c[NGROUPS];
    assign cmsb_o = carry_c[SLICE-1];

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder with valid/ready handshake.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : cla_adder_pipe_if.slave (operands in, registered result out)
// Stage k resolves slice k with the carry registered by stage k-1; a beat
// accepted at edge t is presented after edge t+NSTAGES-1.
// Optional feature: define CLA_PIPE_SUB_EN to add the sub (subtract) input.
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 16
) (
    input  logic           clk,
    input  logic           rst,
    cla_adder_pipe_if.slave bus
);
    localparam int unsigned NSTAGES = cla_nstages(WIDTH, SLICE);

    if (((WIDTH % SLICE) != 0) || ((SLICE % CLA_GROUP) != 0)) begin : g_bad_geometry
        $error("cla_adder_pipe: WIDTH must be a multiple of SLICE and SLICE a multiple of 4");
    end
    if (WIDTH > CLA_MAX_WIDTH) begin : g_too_wide
        $error("cla_adder_pipe: WIDTH exceeds CLA_MAX_WIDTH");
    end

    logic [WIDTH-1:0] opb_c;
    logic             cin_c;
    logic             advance_c;
    cla_stage_t       head_c;
    cla_stage_t       tail_c;
    logic             tail_unused;
    cla_stage_t       src_c   [NSTAGES];
    cla_stage_t       stage_d [NSTAGES];
    cla_stage_t       stage_q [NSTAGES];
    logic [SLICE-1:0] sl_sum  [NSTAGES];
    logic             sl_cout [NSTAGES];
    logic             sl_cmsb [NSTAGES];

    // Subtraction is folded in up front as in0 + ~in1 + 1.
`ifdef CLA_PIPE_SUB_EN
    assign opb_c = bus.sub ? ~bus.in1 : bus.in1;
    assign cin_c = bus.sub ? 1'b1 : bus.carry_in;
`else
    assign opb_c = bus.in1;
    assign cin_c = bus.carry_in;
`endif

    // Whole pipeline moves together; it stalls only when a result is held.
    assign advance_c = !tail_c.valid || bus.out_ready;

    // Incoming beat in pipeline-record form.
    always_comb begin
        head_c       = '0;
        head_c.valid = bus.in_valid;
        head_c.carry = cin_c;
        head_c.opa   = CLA_MAX_WIDTH'(bus.in0);
        head_c.opb   = CLA_MAX_WIDTH'(opb_c);
    end

    // Record feeding each stage's slice adder.
    always_comb begin
        src_c[0] = head_c;
        for (int k = 1; k < int'(NSTAGES); k++) begin
            src_c[k] = stage_q[k-1];
        end
    end

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        cla_slice #(
            .SLICE (SLICE)
        ) u_slice (
            .a_i    (src_c[k].opa[k*SLICE +: SLICE]),
            .b_i    (src_c[k].opb[k*SLICE +: SLICE]),
            .cin_i  (src_c[k].carry),
            .sum_o  (sl_sum[k]),
            .cout_o (sl_cout[k]),
            .cmsb_o (sl_cmsb[k])
        );
    end

    // Merge each slice result into its beat; ovf is only meaningful at the top slice.
    always_comb begin
        for (int k = 0; k < int'(NSTAGES); k++) begin
            stage_d[k]                          = src_c[k];
            stage_d[k].psum[k*SLICE +: SLICE] = sl_sum[k];
            stage_d[k].carry                    = sl_cout[k];
            stage_d[k].ovf                      = sl_cmsb[k] ^ sl_cout[k];
        end
    end

    // Stage registers; bubbles only clear valid so data is sampled on acceptance only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(NSTAGES); k++) begin
                stage_q[k] <= '0;
            end
        end else if (advance_c) begin
            for (int k = 0; k < int'(NSTAGES); k++) begin
                if (src_c[k].valid) begin
                    stage_q[k] <= stage_d[k];
                end else begin
                    stage_q[k].valid <= 1'b0;
                end
            end
        end
    end

    assign tail_c      = stage_q[NSTAGES-1];
    // Upper record bits beyond WIDTH are constant zero in the last stage.
    assign tail_unused = ^tail_c;

    assign bus.in_ready  = advance_c;
    assign bus.out_valid = tail_c.valid;
    assign bus.sum       = tail_c.psum[WIDTH-1:0];
    assign bus.carry_out = tail_c.carry;
    assign bus.overflow  = tail_c.ovf;

endmodule
